spi_reg_bank: RTL and testbench
===============================

SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port ncs, input, 1 bit: SPI chip select, active low, asynchronous to clk.
REQ-004 SHALL have port sclk, input, 1 bit: SPI clock (mode 0), asynchronous to clk.
REQ-005 SHALL have port copi, input, 1 bit: controller-out data, MSB first.
REQ-006 SHALL have port cipo, output, 1 bit: controller-in data, used only with readback (REQ-025).
REQ-007 SHALL have ports en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle, each an 8-bit output: register contents at addresses 0x00 to 0x04, consumed by the downstream PWM stage.
REQ-008 SHALL have port txn_done, output, 1 bit: one-clk pulse per committed write.
REQ-009 SHALL have port frame_err, output, 1 bit: one-clk pulse per discarded frame.

Function
REQ-010 SHALL pass ncs, sclk and copi each through a 2-flop synchronizer before use; the raw inputs SHALL drive no other logic.
REQ-011 SHALL detect sclk rising and falling edges and ncs rising and falling edges from the synchronized signal and one extra delay flop.
REQ-012 SHALL use the frame format bit15 = R/W (1 = write), bits14..8 = address, bits7..0 = data, MSB first.
REQ-013 SHALL, on a detected ncs falling edge, clear the 16-bit shift register and the 5-bit bit counter.
REQ-014 SHALL, on each detected sclk rising edge while synchronized ncs = 0, shift in synchronized copi and increment the bit counter.
REQ-015 SHALL saturate the bit counter at 17; a frame with a count of 17 is overlong.
REQ-016 SHALL evaluate the frame on a detected ncs rising edge.
REQ-017 SHALL commit the write one clk after the ncs rising-edge detect when all of the following hold: count = 16, R/W = 1, address <= 0x04.
REQ-018 SHALL assert txn_done in the same cycle as the commit.
REQ-019 SHALL leave all registers unchanged and pulse frame_err when count is not 16 at ncs rise (short or overlong frame).
REQ-020 SHALL leave all registers unchanged and pulse frame_err on a write to an address above 0x04.
REQ-021 SHALL ignore any sclk edge while synchronized ncs = 1.
REQ-022 SHALL ignore a new ncs falling edge that arrives in the commit cycle until the commit completes; a back-to-back frame SHALL NOT corrupt the commit.
REQ-023 SHALL hold every register stable between commits, so the downstream stage never sees a partial value.

Reset
REQ-024 SHALL, when rst = 1 at a clk edge, set all five registers, the shift register, the bit counter, cipo, txn_done and frame_err to 0, and set the synchronizer ncs flops to 1; reset SHALL abort any frame in progress, with no commit.

Configuration
REQ-025 SHALL, with SPI_READBACK_EN defined, accept R/W = 0 frames with a valid address, loading the addressed register after bit 8 and driving cipo MSB first on each sclk falling edge detected during bits 8..15; a read SHALL pulse txn_done and change no register.
REQ-026 SHALL, without SPI_READBACK_EN, hold cipo at 0 and treat every R/W = 0 frame as discarded with a frame_err pulse.

Structure
REQ-027 SHALL keep the following in a shared package spi_reg_pkg: address constants ADDR_EN_OUT_LO..ADDR_PWM_DUTY (0x00..0x04), ADDR_MAX = 0x04, FRAME_BITS = 16.
REQ-028 SHALL implement each synchronizer as an instance of a sub-module sync2 (2-flop, reset value parameter); all other logic SHALL stay in spi_reg_bank.

Verification
REQ-029 SHALL have a bench case for a valid write: write frame 0x8455 (addr 0x04, data 0x55) -> pwm_duty_cycle = 0x55, one txn_done pulse, other registers 0.
REQ-030 SHALL have a bench case for a bad address: write frame 0x85AA (addr 0x05) -> all registers unchanged, one frame_err pulse.
REQ-031 SHALL have a bench case for a short frame: ncs rises after 12 bits of 0x80FF -> en_reg_out_7_0 stays 0, frame_err pulses.
REQ-032 SHALL have a bench case for back-to-back frames: 0x80F0 then 0x81 0F with ncs high for 2 clk between them -> en_reg_out_7_0 = 0xF0 and en_reg_out_15_8 = 0x0F.
REQ-033 SHALL have a bench case for reset mid-frame: rst asserted after 8 bits of 0x8033 -> all outputs 0, no commit after ncs rises.
REQ-034 SHALL have a bench case for readback (SPI_READBACK_EN only): write 0x823C, then read frame 0x0200 -> cipo shifts out 0x3C during bits 8..15 and en_reg_pwm_7_0 stays 0x3C.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register bank.
// Address map, frame geometry and the frame-control FSM states.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned NUM_REGS   = 5;

  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;
  localparam logic [6:0] ADDR_MAX       = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DONE,
    ST_RESTART
  } state_t;

  function automatic logic addr_ok(input logic [6:0] a);
    return a <= ADDR_MAX;
  endfunction

endpackage

// File: rtl/spi_reg_bank_sync2.sv
// sync2: two-flop synchronizer with a parameterised reset value.
// Ports: clk, rst (sync, active high), d (async in), q (synced out).
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 target writing five 8-bit PWM config regs.
// Ports: clk, rst, ncs/sclk/copi in, cipo out, five reg outputs,
// txn_done / frame_err pulses. SPI_READBACK_EN adds read frames.
import spi_reg_pkg::*;

module spi_reg_bank (
  input  logic       clk,
  input  logic       rst,
  input  logic       ncs,
  input  logic       sclk,
  input  logic       copi,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done,
  output logic       frame_err
);

`ifdef SPI_READBACK_EN
  localparam logic RD_EN = 1'b1;
`else
  localparam logic RD_EN = 1'b0;
`endif

  logic ncs_s, sclk_s, copi_s;
  logic ncs_d, sclk_d;

  sync2 #(.RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .d(ncs), .q(ncs_s)
  );
  sync2 #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
  );
  sync2 #(.RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .d(copi), .q(copi_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_d  <= 1'b1;
      sclk_d <= 1'b0;
    end else begin
      ncs_d  <= ncs_s;
      sclk_d <= sclk_s;
    end
  end

  logic ncs_fall, ncs_rise, sclk_rise;
  assign ncs_fall  = ncs_d & ~ncs_s;
  assign ncs_rise  = ~ncs_d & ncs_s;
  assign sclk_rise = ~sclk_d & sclk_s;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ST_DONE is the commit cycle; a chip-select fall seen there is
  // parked and replayed as a clear in ST_RESTART.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (ncs_rise) state_d = ST_DONE;
      ST_DONE:    state_d = ncs_fall ? ST_RESTART : ST_IDLE;
      ST_RESTART: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  logic [15:0] sr_q;
  logic [15:0] sr_nxt;
  logic [4:0]  cnt_q;
  logic [7:0]  regs_q [NUM_REGS];
  logic        pend_wr_q, pend_ok_q;
  logic [2:0]  pend_idx_q;
  logic [7:0]  pend_data_q;
  logic        clr, shift;
  logic        f_full, f_rw, f_aok;

  assign sr_nxt = {sr_q[14:0], copi_s};
  assign clr    = (state_q == ST_IDLE && ncs_fall)
                | (state_q == ST_RESTART);
  assign shift  = (state_q == ST_IDLE) & sclk_rise & ~ncs_s;
  assign f_full = (cnt_q == CNT_FULL);
  assign f_rw   = sr_q[15];
  assign f_aok  = addr_ok(sr_q[14:8]);

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      pend_wr_q   <= 1'b0;
      pend_ok_q   <= 1'b0;
      pend_idx_q  <= '0;
      pend_data_q <= '0;
      txn_done    <= 1'b0;
      frame_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      txn_done  <= 1'b0;
      frame_err <= 1'b0;
      if (clr) begin
        sr_q  <= '0;
        cnt_q <= '0;
      end else if (shift) begin
        sr_q <= sr_nxt;
        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 5'd1;
      end
      // Frame is judged and latched at the ncs rise so a
      // following frame cannot disturb the commit.
      if (state_q == ST_IDLE && ncs_rise) begin
        pend_wr_q   <= f_full & f_rw & f_aok;
        pend_ok_q   <= f_full & f_aok & (f_rw | RD_EN);
        pend_idx_q  <= sr_q[10:8];
        pend_data_q <= sr_q[7:0];
      end
      if (state_q == ST_DONE) begin
        if (pend_wr_q) regs_q[pend_idx_q] <= pend_data_q;
        txn_done  <= pend_ok_q;
        frame_err <= ~pend_ok_q;
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO[2:0]];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI[2:0]];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO[2:0]];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI[2:0]];
  assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY[2:0]];

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [7:0] rd_sr_q;
  logic       rd_act_q, cipo_q;
  logic       rd_hit;

  assign sclk_fall = sclk_d & ~sclk_s;
  assign rd_hit    = ~sr_nxt[7] & addr_ok(sr_nxt[6:0]);

  // Header is complete on the 8th rising edge; data leaves on the
  // falls that follow, one bit ahead of the controller's sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sr_q  <= '0;
      rd_act_q <= 1'b0;
      cipo_q   <= 1'b0;
    end else if (clr || ncs_rise) begin
      rd_act_q <= 1'b0;
      cipo_q   <= 1'b0;
    end else if (shift && cnt_q == 5'd7) begin
      rd_act_q <= rd_hit;
      rd_sr_q  <= rd_hit ? regs_q[sr_nxt[2:0]] : 8'h00;
    end else if (sclk_fall && !ncs_s && rd_act_q
                 && cnt_q >= 5'd8 && cnt_q <= 5'd15) begin
      cipo_q  <= rd_sr_q[7];
      rd_sr_q <= {rd_sr_q[6:0], 1'b0};
    end
  end

  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomised + directed bench for spi_reg_bank against a frame-level
// model. Define SPI_READBACK_EN to exercise read frames.
module tb_spi_reg_bank;

`ifdef SPI_READBACK_EN
  localparam bit RD = 1'b1;
`else
  localparam bit RD = 1'b0;
`endif
  localparam time HALF = 60ns;

  logic       clk = 1'b0;
  logic       rst, ncs, sclk, copi, cipo;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       txn_done, frame_err;

  spi_reg_bank dut (
    .clk(clk), .rst(rst), .ncs(ncs), .sclk(sclk), .copi(copi),
    .cipo(cipo),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1),
    .en_reg_pwm_7_0(r2), .en_reg_pwm_15_8(r3),
    .pwm_duty_cycle(r4),
    .txn_done(txn_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_txn = 0;
  int n_err = 0;
  int exp_txn = 0;
  int exp_err = 0;
  logic [7:0] m_regs [5];
  logic [7:0] rd_cap;

  always @(negedge clk) begin
    if (txn_done)  n_txn++;
    if (frame_err) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".r0"}, 32'(r0), 32'(m_regs[0]));
    chk({tag, ".r1"}, 32'(r1), 32'(m_regs[1]));
    chk({tag, ".r2"}, 32'(r2), 32'(m_regs[2]));
    chk({tag, ".r3"}, 32'(r3), 32'(m_regs[3]));
    chk({tag, ".r4"}, 32'(r4), 32'(m_regs[4]));
    chk({tag, ".txn"}, 32'(n_txn), 32'(exp_txn));
    chk({tag, ".err"}, 32'(n_err), 32'(exp_err));
  endtask

  // Frame-level reference: a frame counts only if exactly 16 bits
  // arrived, the address is in 0..4 and it is a write (or a read
  // when readback exists).
  task automatic model(input logic [15:0] w, input int nbits,
                       output logic [7:0] exp_rd);
    int  a;
    bit  ok;
    a = int'(w[14:8]);
    exp_rd = 8'h00;
    if (RD && nbits >= 16 && !w[15] && a <= 4) exp_rd = m_regs[a];
    ok = (nbits == 16) && (a <= 4) && (w[15] || RD);
    if (ok) exp_txn++;
    else    exp_err++;
    if (ok && w[15]) m_regs[a] = w[7:0];
  endtask

  // Drive one frame; optional reset pulse after rst_after bits.
  task automatic send(input logic [15:0] w, input int nbits,
                      input int rst_after, input int gap);
    rd_cap = 8'h00;
    ncs = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < 16) ? w[15-i] : 1'($urandom % 2);
      #(HALF);
      if (i >= 8 && i < 16) rd_cap[15-i] = cipo;
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
      if (i + 1 == rst_after) begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
    end
    #(HALF);
    ncs = 1'b1;
    #(gap * 10);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  erd;
    logic [15:0] w;
    int          nb, sel, gap;
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    idle(4);
    rst = 1'b0;
    idle(2);
    chk_all("reset");
    chk("reset.cipo", 32'(cipo), 32'h0);
    chk("reset.pulse", 32'({txn_done, frame_err}), 32'h0);

    // sclk activity with chip select high must be ignored
    repeat (5) begin
      sclk = 1'b1; #(HALF); sclk = 1'b0; #(HALF);
    end

    send(16'h8455, 16, -1, 8); model(16'h8455, 16, erd);
    idle(4); chk_all("wr_duty");
    chk("wr_duty.val", 32'(r4), 32'h55);

    send(16'h85AA, 16, -1, 8); model(16'h85AA, 16, erd);
    idle(4); chk_all("bad_addr");

    send(16'h80FF, 12, -1, 8); model(16'h80FF, 12, erd);
    idle(4); chk_all("short");

    send(16'h80FF, 17, -1, 8); model(16'h80FF, 17, erd);
    idle(4); chk_all("long");

    send(16'h80F0, 16, -1, 2); model(16'h80F0, 16, erd);
    send(16'h810F, 16, -1, 8); model(16'h810F, 16, erd);
    idle(4); chk_all("b2b");
    chk("b2b.lo", 32'(r0), 32'hF0);
    chk("b2b.hi", 32'(r1), 32'h0F);

    // reset mid-frame: regs clear, the tail becomes a short frame
    send(16'h8033, 16, 8, 8);
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    exp_err++;
    idle(4); chk_all("rst_mid");

    send(16'h823C, 16, -1, 8); model(16'h823C, 16, erd);
    send(16'h0200, 16, -1, 8); model(16'h0200, 16, erd);
    idle(4); chk_all("read");
    chk("read.cipo", 32'(rd_cap), 32'(erd));
    chk("read.reg", 32'(r2), 32'h3C);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom % 8);
      nb  = (sel < 5) ? 16 : (sel == 5) ? 12 : (sel == 6) ? 17 : 20;
      w[15]   = ($urandom % 4) != 0;
      w[14:8] = 7'($urandom % 8);
      w[7:0]  = 8'($urandom);
      gap = ($urandom % 3 == 0) ? 1 : 8;
      send(w, nb, -1, gap);
      model(w, nb, erd);
      if (nb >= 16) chk("rnd.cipo", 32'(rd_cap), 32'(erd));
    end
    idle(10);
    chk_all("rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
